led_fader: RTL and testbench
============================

# led_fader

Per-LED PWM fade engine sitting directly downstream of the 26-bit LED output register. It consumes the register's static on/off pattern and drives the board LEDs. Each LED ramps its brightness one level per fade step toward full-on or full-off, and a shared PWM counter turns each brightness level into a duty cycle. Software writes an on/off pattern as before, and the transitions become smooth fades.

## Interface
- `N_LEDS`, default 26: number of LED channels; matches the output register width.
- `LEVEL_W`, default 4: brightness level width; levels run 0..2^LEVEL_W-1.
- `STEP_DIV`, default 50000: clocks per fade step; legal range ≥2.
- `clk`, in, 1: system clock. One clock domain only.
- `reset`, in, 1: asynchronous, active-high reset.
- `pattern_in`, in, N_LEDS: target pattern, fed by the LED register output. 1 = on, 0 = off.
- `hold`, in, 1: when 1, fading freezes. PWM output continues.
- `led_out`, out, N_LEDS: registered PWM drive to the LED pins.
- `busy`, out, 1: registered; 1 while any channel level differs from its target extreme.

## Operation
- **Prescaler:** counts 0..STEP_DIV-1 and wraps to 0. `step` is asserted combinationally in the cycle the prescaler equals STEP_DIV-1 and `hold`=0. While `hold`=1, the prescaler holds its value.
- **PWM counter** `pwm_cnt`: counts 0..2^LEVEL_W-2 and wraps, giving a period of 15 clocks at the default width. It never freezes.
- **Per-channel level** `level[i]`, LEVEL_W bits, updated on each `step`:
  - `pattern_in[i]`=1 and `level[i]`<max: increment by 1.
  - `pattern_in[i]`=0 and `level[i]`>0: decrement by 1.
  - Otherwise: hold. The level saturates at both ends and never wraps.
- **Target change mid-ramp:** the direction reverses at the next `step`, starting from the current level. The level never jumps.
- **PWM output:** `led_out[i]` <= (`duty[i]` > `pwm_cnt`), where `duty[i]` = `level[i]`.
  - Level 0 gives a constant 0.
  - Max level gives a constant 1.
  - Level k gives k high cycles per period.
- **Busy:** `busy` <= OR over all channels of (`level[i]` != (`pattern_in[i]` ? max : 0)).
- `pattern_in` is sampled every clock. Only its value in a `step` cycle affects the level.

## Timing
- **Reset values:** prescaler=0, `pwm_cnt`=0, all levels=0, `led_out`=0, `busy`=0.
- **Clock after reset release:** `busy` reflects `pattern_in`.
- **Step latency:** the level updates on the clock edge that ends the `step` cycle. `led_out` reflects the new level one clock later.
- **Full ramp time:** 0→max takes 15 steps (15·STEP_DIV clocks); max→0 takes the same.
- **Reset mid-ramp:** all levels and `led_out` go to 0 immediately and asynchronously. There is no resume.
- **`hold` and `step`:** `hold` asserted in the would-be `step` cycle suppresses that step. The step fires in the first cycle after `hold` deasserts, because the prescaler is still at STEP_DIV-1.

## Configuration
- **`LED_FADER_GAMMA_EN` defined:** `duty[i]` = GAMMA[`level[i]`], a 16-entry perceptual table:
  - Entries: 0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15.
  - Monotonic, with GAMMA[0]=0 and GAMMA[15]=15, so the endpoints are unchanged.
  - Only legal with LEVEL_W=4; elaboration error otherwise.
- **Macro undefined:** `duty[i]` = `level[i]` (linear).
- **Unaffected either way:** levels, `busy` and timing.

## Structure
- **`led_pkg` shared package** holds:
  - `LEVEL_W` default and `LEVEL_MAX` constant.
  - A `level_t` typedef.
  - The `GAMMA` table as a constant function.
- **Sub-module `led_fade_channel`**: level up/down saturating counter, duty mapping and output comparator. The top instantiates it N_LEDS times via generate. The top owns the prescaler, `pwm_cnt` and the `busy` reduction.

## Test plan
All scenarios use STEP_DIV=4.
- **Reset:** assert `reset` with `pattern_in`=all ones → `led_out`=0, `busy`=0 immediately. Release → `busy`=1 the next clock, and level[0] reaches 15 after 60 clocks.
- **Full ramp:** `pattern_in`=26'h0000001 from level 0 → level[0] increments every 4 clocks. After ramp completion `led_out[0]` is constant 1 and `busy`=0. Other bits stay 0.
- **Duty check:** hold level 5 via `hold`=1 → `led_out[0]` is high exactly 5 of every 15 clocks, aligned to `pwm_cnt`=0..4.
- **Reversal:** ramp bit 3 to level 7, then clear `pattern_in[3]` → the next step gives 6. There is no jump, and the level reaches 0 after 7 more steps.
- **Hold at step boundary:** assert `hold` in the `step` cycle for 10 clocks → the level is unchanged, and the step fires on the first clock after deassertion.
- **Gamma:** with `LED_FADER_GAMMA_EN`, level 12 → 8 high cycles per 15. Without the macro → 12 high cycles.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade engine: default level width,
// level ceiling, and the perceptual gamma table used when LED_FADER_GAMMA_EN is defined.
package led_pkg;

  localparam int DEF_LEVEL_W = 4;
  localparam int LEVEL_MAX   = (1 << DEF_LEVEL_W) - 1;

  typedef logic [DEF_LEVEL_W-1:0] level_t;

  // Monotonic perceptual curve; endpoints map to themselves so full-on/off stay exact.
  function automatic level_t gamma(input level_t lvl);
    case (lvl)
      4'd0, 4'd1, 4'd2: gamma = 4'd0;
      4'd3, 4'd4, 4'd5: gamma = 4'd1;
      4'd6, 4'd7:       gamma = 4'd2;
      4'd8:             gamma = 4'd3;
      4'd9:             gamma = 4'd4;
      4'd10:            gamma = 4'd5;
      4'd11:            gamma = 4'd6;
      4'd12:            gamma = 4'd8;
      4'd13:            gamma = 4'd10;
      4'd14:            gamma = 4'd12;
      default:          gamma = 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness ramp, duty mapping and PWM comparator.
// Duty is linear unless LED_FADER_GAMMA_EN is defined, which selects the gamma table.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               target,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic [LEVEL_W-1:0] level,
  output logic               led_out
);

  localparam logic [LEVEL_W-1:0] LVL_TOP = '1;

  logic [LEVEL_W-1:0] duty;

  // NOTE: level is a plain register, not a memory, so it is safe and intended
  // to clear it in the async reset branch; non-blocking keeps the update race-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (step) begin
      if (target && level != LVL_TOP)
        level <= level + 1'b1;
      else if (!target && level != '0)
        level <= level - 1'b1;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  if (LEVEL_W != 4) begin : g_bad_width
    $error("led_fade_channel: LED_FADER_GAMMA_EN requires LEVEL_W == 4");
  end
  assign duty = LEVEL_W'(gamma(level_t'(level)));
`else
  assign duty = level;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_out <= 1'b0;
    else       led_out <= (duty > pwm_cnt);
  end

endmodule

// File: rtl/led_fader.sv
// Per-LED PWM fade engine: shared step prescaler and PWM counter, N_LEDS fade channels
// and a registered busy flag. Optional gamma duty mapping via LED_FADER_GAMMA_EN.
module led_fader
  import led_pkg::*;
#(
  parameter int N_LEDS   = 26,
  parameter int LEVEL_W  = DEF_LEVEL_W,
  parameter int STEP_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              hold,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int                 PRE_W    = $clog2(STEP_DIV);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(STEP_DIV - 1);
  // PWM period is 2^LEVEL_W-1 so the top level is a constant 1.
  localparam logic [LEVEL_W-1:0] PWM_LAST = LEVEL_W'((1 << LEVEL_W) - 2);

  logic [PRE_W-1:0]   prescaler;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic               step;
  logic [LEVEL_W-1:0] level [N_LEDS];
  logic [N_LEDS-1:0]  off_target;

  assign step = (prescaler == PRE_LAST) && !hold;

  // hold freezes the prescaler at its value, so a suppressed step fires right after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prescaler <= '0;
    else if (!hold)
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    led_fade_channel #(
      .LEVEL_W(LEVEL_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .step   (step),
      .target (pattern_in[g]),
      .pwm_cnt(pwm_cnt),
      .level  (level[g]),
      .led_out(led_out[g])
    );
    assign off_target[g] = (level[g] != {LEVEL_W{pattern_in[g]}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= 1'b0;
    else       busy <= |off_target;
  end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader (STEP_DIV=4): a cycle model pushes expected outputs
// to a scoreboard queue at each edge, popped and compared at the following negedge.
module tb_led_fader;

  localparam int N    = 26;
  localparam int LW   = 4;
  localparam int SD   = 4;
  localparam int LMAX = 15;
  localparam int GT [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         hold = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic [N-1:0] led_out;
  logic         busy;

  led_fader #(.N_LEDS(N), .LEVEL_W(LW), .STEP_DIV(SD)) dut (
    .clk       (clk),
    .reset     (reset),
    .pattern_in(pattern_in),
    .hold      (hold),
    .led_out   (led_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [N-1:0] led;
    logic         busy;
    int           lvl0;
  } exp_t;

  exp_t sb[$];
  int   m_pre, m_pwm;
  int   m_lvl [N];

  function automatic int duty(input int l);
`ifdef LED_FADER_GAMMA_EN
    return GT[l];
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    m_pre = 0;
    m_pwm = 0;
    for (int i = 0; i < N; i++) m_lvl[i] = 0;
  endtask

  // One clock: advance the model at the edge, compare DUT at the negedge.
  task automatic clk_cycle();
    exp_t e;
    logic st;
    @(posedge clk);
    st     = (m_pre == SD - 1) && !hold;
    e.busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.led[i] = (duty(m_lvl[i]) > m_pwm);
      if (m_lvl[i] != (pattern_in[i] ? LMAX : 0)) e.busy = 1'b1;
      if (st) begin
        if (pattern_in[i] && m_lvl[i] < LMAX) m_lvl[i]++;
        else if (!pattern_in[i] && m_lvl[i] > 0) m_lvl[i]--;
      end
    end
    if (!hold) m_pre = (m_pre == SD - 1) ? 0 : m_pre + 1;
    m_pwm  = (m_pwm == LMAX - 1) ? 0 : m_pwm + 1;
    e.lvl0 = m_lvl[0];
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("led_out", 32'(led_out), 32'(e.led));
    check("busy", 32'(busy), 32'(e.busy));
    check("level0", 32'(dut.level[0]), 32'(e.lvl0));
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_led_async", 32'(led_out), 32'd0);
    check("rst_busy_async", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until(input int ch, input int val, input string tag);
    int k = 0;
    while (m_lvl[ch] != val && k < 400) begin
      clk_cycle();
      k++;
    end
    if (m_lvl[ch] != val) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int c = 0; c < n; c++) begin
      clk_cycle();
      if (led_out[ch]) hi++;
    end
  endtask

  initial begin
    int hi;
    int lv;
    int k;

    // Reset with all targets on, then full ramp of every channel.
    @(negedge clk);
    pattern_in = '1;
    do_reset();
    clk_cycle();
    check("busy_after_release", 32'(busy), 32'd1);
    repeat (59) clk_cycle();
    check("lvl0_at_60", 32'(dut.level[0]), 32'd15);
    repeat (2) clk_cycle();
    check("busy_all_on", 32'(busy), 32'd0);

    // Single-channel ramp; reset lands mid-activity with LEDs lit.
    do_reset();
    pattern_in = 26'h0000001;
    repeat (62) clk_cycle();
    count_high(0, 15, hi);
    check("full_on_high_cycles", 32'(hi), 32'd15);
    check("other_bits_off", 32'(led_out[N-1:1]), 32'd0);
    check("busy_done", 32'(busy), 32'd0);

    // Duty at held levels 5 and 12.
    do_reset();
    pattern_in = 26'h0000001;
    run_until(0, 5, "ramp5");
    hold = 1'b1;
    repeat (2) clk_cycle();
    count_high(0, 15, hi);
    check("duty_lvl5", 32'(hi), 32'(duty(5)));
    hold = 1'b0;
    run_until(0, 12, "ramp12");
    hold = 1'b1;
    repeat (2) clk_cycle();
    count_high(0, 15, hi);
    check("duty_lvl12", 32'(hi), 32'(duty(12)));
    hold = 1'b0;

    // hold asserted in the would-be step cycle.
    k = 0;
    while (m_pre != SD - 1 && k < 8) begin
      clk_cycle();
      k++;
    end
    if (m_pre != SD - 1) check("pre_align_timeout", 32'd0, 32'd1);
    lv   = m_lvl[0];
    hold = 1'b1;
    repeat (10) clk_cycle();
    check("hold_level_frozen", 32'(dut.level[0]), 32'(lv));
    hold = 1'b0;
    clk_cycle();
    check("step_after_hold", 32'(dut.level[0]), 32'(lv + 1));

    // Reversal mid-ramp on bit 3.
    do_reset();
    pattern_in = 26'h0000008;
    run_until(3, 7, "ramp7");
    pattern_in = '0;
    repeat (4) clk_cycle();
    check("reverse_first_step", 32'(dut.level[3]), 32'd6);
    repeat (24) clk_cycle();
    check("reverse_to_zero", 32'(dut.level[3]), 32'd0);
    clk_cycle();
    check("busy_after_reverse", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
